roic_spi_init_seq: RTL and testbench

- Table-driven configuration sequencer for the ROIC SPI master (roic_spi).
- On start, fetches {cmd, addr, data} entries from an external init table (ROM/BRAM, 1-cycle read latency).
- For each write entry, drives address/data/DUT_EN/spiReady and waits for the transaction to finish, with programmable delay entries and timeout/abort handling.
- Sits between the top-level power-up/reconfig control and roic_spi.

---
 rtl/roic_spi_init_seq.sv | 234 +++++++++++++++++++++++
 tb/tb_roic_spi_init_seq.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/roic_spi_init_seq.sv
// roic_spi_init_seq: walks an external init table and feeds each write entry
// to roic_spi (address/data/DUT_EN/spiReady). Delay entries insert idle time.
// Start and transfer phases are bounded by timeouts, and an abort drains any
// transaction already in flight before the sequence ends.
module roic_spi_init_seq #(
    parameter int unsigned IDX_W         = 8,
    parameter int unsigned READY_CYCLES  = 2,
    parameter int unsigned START_TIMEOUT = 16,
    parameter int unsigned XFER_TIMEOUT  = 4096,
    parameter int unsigned GAP_CYCLES    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [IDX_W:0]   num_entries,
    output logic             tbl_rd,
    output logic [IDX_W-1:0] tbl_addr,
    input  logic [24:0]      tbl_q,
    input  logic             spi_busy,
    output logic [7:0]       address,
    output logic [15:0]      data,
    output logic             DUT_EN,
    output logic             spiReady,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [1:0]       err_code,
    output logic [IDX_W-1:0] err_index,
    output logic [IDX_W:0]   wr_count
);

    localparam int unsigned TMO_MAX = (START_TIMEOUT > XFER_TIMEOUT) ? START_TIMEOUT : XFER_TIMEOUT;
    localparam int unsigned TMO_W   = $clog2(TMO_MAX) + 1;
    localparam logic [TMO_W-1:0] START_LIM = TMO_W'(START_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] XFER_LIM  = TMO_W'(XFER_TIMEOUT - 1);
    localparam logic [15:0] READY_INIT = 16'(READY_CYCLES - 1);
    localparam logic [15:0] GAP_INIT   = (GAP_CYCLES == 0) ? 16'd0 : 16'(GAP_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_LATCH, S_ISSUE, S_WAIT_START,
        S_WAIT_DONE, S_GAP, S_DELAY, S_DRAIN, S_DONE
    } state_t;

    state_t             state_q;
    logic               tbl_rd_q;
    logic [IDX_W-1:0]   tbl_addr_q;
    logic [7:0]         address_q;
    logic [15:0]        data_q;
    logic               dut_en_q;
    logic               spi_ready_q;
    logic               busy_q;
    logic               done_q;
    logic               error_q;
    logic [1:0]         err_code_q;
    logic [IDX_W-1:0]   err_index_q;
    logic [IDX_W:0]     wr_count_q;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W:0]     n_q;
    logic [15:0]        cnt_q;
    logic [TMO_W-1:0]   tmo_q;

    logic               advance_d;
    logic [IDX_W:0]     idx_ext_d;
    logic               last_entry_d;
    logic               abort_hit_d;

    assign idx_ext_d    = {1'b0, idx_q} + (IDX_W + 1)'(1);
    assign last_entry_d = (idx_ext_d == n_q);
    // abort only matters once a run is active and not already winding down
    assign abort_hit_d  = abort && (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_DRAIN);

    // decide when the current entry is finished and the next one should start
    always_comb begin
        advance_d = 1'b0;
        case (state_q)
            S_GAP:       advance_d = (cnt_q == 16'd0);
            S_DELAY:     advance_d = (cnt_q <= 16'd1);
            S_WAIT_DONE: advance_d = !spi_busy && (GAP_CYCLES == 0);
            default:     advance_d = 1'b0;
        endcase
    end

    // sequencer state and all registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            tbl_rd_q    <= 1'b0;
            tbl_addr_q  <= '0;
            address_q   <= '0;
            data_q      <= '0;
            dut_en_q    <= 1'b0;
            spi_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= '0;
            err_index_q <= '0;
            wr_count_q  <= '0;
            idx_q       <= '0;
            n_q         <= '0;
            cnt_q       <= '0;
            tmo_q       <= '0;
        end else begin
            done_q   <= 1'b0;
            tbl_rd_q <= 1'b0;
            if (abort_hit_d) begin
                error_q     <= 1'b1;
                err_code_q  <= 2'b11;
                err_index_q <= idx_q;
                spi_ready_q <= 1'b0;
                tmo_q       <= '0;
                if ((state_q == S_WAIT_START || state_q == S_WAIT_DONE) && spi_busy)
                    state_q <= S_DRAIN;
                else
                    state_q <= S_DONE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start && !abort) begin
                            error_q     <= 1'b0;
                            err_code_q  <= '0;
                            err_index_q <= '0;
                            wr_count_q  <= '0;
                            n_q         <= num_entries;
                            idx_q       <= '0;
                            busy_q      <= 1'b1;
                            if (num_entries == '0) begin
                                state_q <= S_DONE;
                            end else begin
                                tbl_rd_q   <= 1'b1;
                                tbl_addr_q <= '0;
                                state_q    <= S_FETCH;
                            end
                        end
                    end
                    S_FETCH: state_q <= S_LATCH;
                    S_LATCH: begin
                        if (tbl_q[24]) begin
                            cnt_q   <= tbl_q[15:0];
                            state_q <= S_DELAY;
                        end else begin
                            address_q   <= tbl_q[23:16];
                            data_q      <= tbl_q[15:0];
                            dut_en_q    <= 1'b1;
                            spi_ready_q <= 1'b1;
                            cnt_q       <= READY_INIT;
                            state_q     <= S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        if (cnt_q == 16'd0) begin
                            spi_ready_q <= 1'b0;
                            tmo_q       <= '0;
                            state_q     <= S_WAIT_START;
                        end else begin
                            cnt_q <= cnt_q - 16'd1;
                        end
                    end
                    S_WAIT_START: begin
                        if (spi_busy) begin
                            tmo_q   <= '0;
                            state_q <= S_WAIT_DONE;
                        end else if (tmo_q == START_LIM) begin
                            error_q     <= 1'b1;
                            err_code_q  <= 2'b01;
                            err_index_q <= idx_q;
                            state_q     <= S_DONE;
                        end else begin
                            tmo_q <= tmo_q + TMO_W'(1);
                        end
                    end
                    S_WAIT_DONE: begin
                        if (!spi_busy) begin
                            wr_count_q <= wr_count_q + (IDX_W + 1)'(1);
                            cnt_q      <= GAP_INIT;
                            state_q    <= S_GAP;
                        end else if (tmo_q == XFER_LIM) begin
                            error_q     <= 1'b1;
                            err_code_q  <= 2'b10;
                            err_index_q <= idx_q;
                            state_q     <= S_DONE;
                        end else begin
                            tmo_q <= tmo_q + TMO_W'(1);
                        end
                    end
                    S_GAP: begin
                        if (cnt_q != 16'd0) cnt_q <= cnt_q - 16'd1;
                    end
                    S_DELAY: begin
                        if (cnt_q > 16'd1) cnt_q <= cnt_q - 16'd1;
                    end
                    S_DRAIN: begin
                        if (!spi_busy || tmo_q == XFER_LIM) state_q <= S_DONE;
                        else tmo_q <= tmo_q + TMO_W'(1);
                    end
                    S_DONE: begin
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        dut_en_q    <= 1'b0;
                        spi_ready_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
                // shared end-of-entry step; overrides the per-state transition above
                if (advance_d) begin
                    if (last_entry_d) begin
                        state_q <= S_DONE;
                    end else begin
                        idx_q      <= idx_ext_d[IDX_W-1:0];
                        tbl_rd_q   <= 1'b1;
                        tbl_addr_q <= idx_ext_d[IDX_W-1:0];
                        state_q    <= S_FETCH;
                    end
                end
            end
        end
    end

    assign tbl_rd    = tbl_rd_q;
    assign tbl_addr  = tbl_addr_q;
    assign address   = address_q;
    assign data      = data_q;
    assign DUT_EN    = dut_en_q;
    assign spiReady  = spi_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign err_code  = err_code_q;
    assign err_index = err_index_q;
    assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_roic_spi_init_seq.sv
// Bench for roic_spi_init_seq: table ROM model, behavioural SPI slave,
// entry-level reference model and a per-cycle output monitor.
module tb_roic_spi_init_seq;

    localparam int IDX_W    = 8;
    localparam int READY    = 2;
    localparam int START_TO = 16;
    localparam int XFER_TO  = 4096;
    localparam int GAP      = 4;

    logic             clk;
    logic             reset;
    logic             start;
    logic             abort;
    logic [IDX_W:0]   num_entries;
    logic             tbl_rd;
    logic [IDX_W-1:0] tbl_addr;
    logic [24:0]      tbl_q;
    logic             spi_busy;
    logic [7:0]       address;
    logic [15:0]      data;
    logic             DUT_EN;
    logic             spiReady;
    logic             busy;
    logic             done;
    logic             error;
    logic [1:0]       err_code;
    logic [IDX_W-1:0] err_index;
    logic [IDX_W:0]   wr_count;

    roic_spi_init_seq #(
        .IDX_W(IDX_W), .READY_CYCLES(READY), .START_TIMEOUT(START_TO),
        .XFER_TIMEOUT(XFER_TO), .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .num_entries(num_entries), .tbl_rd(tbl_rd), .tbl_addr(tbl_addr),
        .tbl_q(tbl_q), .spi_busy(spi_busy), .address(address), .data(data),
        .DUT_EN(DUT_EN), .spiReady(spiReady), .busy(busy), .done(done),
        .error(error), .err_code(err_code), .err_index(err_index),
        .wr_count(wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // table memory: one-cycle read latency, garbage when not read
    logic [24:0] rom [256];
    always @(posedge clk) tbl_q <= tbl_rd ? rom[tbl_addr] : 25'($urandom);

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic bound_fail(input string nm, input int waited);
        vectors++;
        miscompares++;
        $display("FAIL %s: waited %0d cycles, event never occurred", nm, waited);
    endtask

    // ---------------- behavioural SPI slave ----------------
    int slv_lat = 3, slv_hold = 40, slv_rand = 0;
    int slv_skip_ord = -1, slv_long_ord = -1, slv_ord = 0, slv_cur = -1;
    int slv_fall_t = 0, s_lat, s_hold;
    bit slv_active = 0, rdy_prev = 0;

    initial begin
        spi_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (spiReady && !rdy_prev) begin
                s_lat  = slv_rand ? int'($urandom_range(1, 6)) : slv_lat;
                s_hold = slv_rand ? int'($urandom_range(3, 30)) : slv_hold;
                if (slv_ord == slv_long_ord) s_hold = XFER_TO + 200;
                if (slv_ord != slv_skip_ord) begin
                    slv_active = 1;
                    slv_cur = slv_ord;
                    repeat (s_lat) @(negedge clk);
                    spi_busy = 1'b1;
                    repeat (s_hold) @(negedge clk);
                    spi_busy = 1'b0;
                    slv_fall_t = cyc;
                    slv_active = 0;
                end
                slv_ord++;
            end
            rdy_prev = spiReady;
        end
    end

    // ---------------- reference model (entry level) ----------------
    int exp_fetch[$];
    logic [23:0] exp_wr[$];
    int e_wrc, e_err, e_code, e_idx, abort_ord;

    task automatic build_model(input int n, input int skip, input int longe, input int ab);
        int ord;
        exp_fetch.delete();
        exp_wr.delete();
        e_wrc = 0; e_err = 0; e_code = 0; e_idx = 0;
        slv_skip_ord = -1; slv_long_ord = -1; abort_ord = -1;
        ord = 0;
        for (int i = 0; i < n; i++) begin
            exp_fetch.push_back(i);
            if (rom[i][24]) continue;
            exp_wr.push_back(rom[i][23:0]);
            if (i == skip)  begin slv_skip_ord = ord; e_err = 1; e_code = 1; e_idx = i; break; end
            if (i == longe) begin slv_long_ord = ord; e_err = 1; e_code = 2; e_idx = i; break; end
            if (i == ab)    begin abort_ord = ord;    e_err = 1; e_code = 3; e_idx = i; break; end
            e_wrc++;
            ord++;
        end
    endtask

    // ---------------- per-cycle monitor ----------------
    bit sup_width = 0, rdy_m = 0, err_m = 0, done_m = 0;
    int rdy_w = 0, done_cnt = 0, done_t = 0, err_rise_t = 0, rdy_fall_t = 0, start_t = 0;
    logic [23:0] cur_ad;
    logic [IDX_W:0] wrc_m = '0;
    int rise_t[$];
    int wrc_t[$];

    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (tbl_rd) begin
                    if (exp_fetch.size() == 0) chk("unexpected_tbl_rd", tbl_addr, -1);
                    else chk("tbl_addr", tbl_addr, exp_fetch.pop_front());
                end
                if (spiReady && !rdy_m) begin
                    rise_t.push_back(cyc);
                    rdy_w = 1;
                    cur_ad = {address, data};
                    if (exp_wr.size() == 0) chk("unexpected_spiReady", {address, data}, -1);
                    else chk("spi_addr_data", {address, data}, exp_wr.pop_front());
                    chk("DUT_EN_at_ready", DUT_EN, 1);
                end else if (spiReady) begin
                    rdy_w++;
                    chk("addr_data_stable", {address, data}, cur_ad);
                end
                if (!spiReady && rdy_m) begin
                    rdy_fall_t = cyc;
                    if (!sup_width) chk("spiReady_width", rdy_w, READY);
                end
                if (wr_count != wrc_m && wr_count != '0) wrc_t.push_back(cyc);
                if (error && !err_m) err_rise_t = cyc;
                if (!busy) chk("idle_quiet", {DUT_EN, spiReady, tbl_rd}, 0);
                if (done) begin
                    done_cnt++;
                    done_t = cyc;
                    chk("done_one_cycle", done_m, 0);
                    chk("done_wr_count", wr_count, e_wrc);
                    chk("done_error", error, e_err);
                    chk("done_err_code", err_code, e_code);
                    if (e_err != 0) chk("done_err_index", err_index, e_idx);
                end
            end
            rdy_m = spiReady; err_m = error; wrc_m = wr_count; done_m = done;
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_slave_idle();
        int t = 0;
        while ((slv_active || spi_busy) && t < 20000) begin @(negedge clk); t++; end
        if (t >= 20000) bound_fail("slave_idle", t);
    endtask

    task automatic run_seq(input int n, input int skip, input int longe, input int ab, input bit poke);
        int t, d0;
        wait_slave_idle();
        build_model(n, skip, longe, ab);
        slv_ord = 0; slv_cur = -1;
        rise_t.delete(); wrc_t.delete();
        d0 = done_cnt;
        @(negedge clk);
        num_entries = (IDX_W + 1)'(n);
        start = 1'b1;
        start_t = cyc;
        @(negedge clk);
        start = 1'b0;
        if (ab >= 0) begin
            t = 0;
            while (!(spi_busy && slv_cur == abort_ord) && t < 5000) begin @(negedge clk); t++; end
            if (t >= 5000) bound_fail("abort_window", t);
            repeat (2) @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
        end
        if (poke) begin
            repeat ($urandom_range(2, 20)) @(negedge clk);
            if (busy) begin
                start = 1'b1;
                num_entries = (IDX_W + 1)'($urandom_range(1, 9));
                @(negedge clk);
                start = 1'b0;
            end
        end
        t = 0;
        while (done_cnt == d0 && t < 30000) begin @(negedge clk); t++; end
        if (t >= 30000) bound_fail("done_wait", t);
        repeat (3) @(negedge clk);
        chk("single_done", done_cnt - d0, 1);
        chk("fetches_consumed", exp_fetch.size(), 0);
        chk("writes_consumed", exp_wr.size(), 0);
    endtask

    task automatic load3();
        rom[0] = {1'b0, 8'hA5, 16'h1234};
        rom[1] = {1'b0, 8'h5A, 16'h5678};
        rom[2] = {1'b0, 8'hFF, 16'hABCD};
    endtask

    initial begin
        int t, n, sk;
        reset = 1'b1; start = 1'b0; abort = 1'b0; num_entries = '0;
        for (int i = 0; i < 256; i++) rom[i] = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {tbl_rd, tbl_addr, address, data, DUT_EN, spiReady, busy,
                              done, error, err_code, err_index, wr_count}, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // three writes, slave: busy 3 cycles after spiReady for 40 cycles
        load3();
        run_seq(3, -1, -1, -1, 0);
        chk("model_pin_wrc3", e_wrc, 3);
        chk("t1_wr_count", wr_count, 3);
        chk("t1_error", error, 0);
        chk("t1_pulses", rise_t.size(), 3);

        // empty table: done two cycles after start, nothing issued
        run_seq(0, -1, -1, -1, 0);
        chk("t2_done_latency", done_t - start_t, 2);
        chk("t2_no_spiReady", rise_t.size(), 0);
        chk("t2_wr_count", wr_count, 0);

        // write / delay 100 / write; from wr_count step (first gap cycle):
        // 4 gap + fetch + latch + 100 delay + fetch + latch = 108 cycles
        rom[0] = {1'b0, 8'h11, 16'h1111};
        rom[1] = {1'b1, 8'h00, 16'd100};
        rom[2] = {1'b0, 8'h22, 16'h2222};
        run_seq(3, -1, -1, -1, 0);
        chk("t3_wr_count", wr_count, 2);
        if (rise_t.size() >= 2 && wrc_t.size() >= 1) chk("t3_delay_spacing", rise_t[1] - wrc_t[0], 108);
        else bound_fail("t3_events", rise_t.size());

        // slave silent on entry 0: start timeout
        load3();
        run_seq(3, 0, -1, -1, 0);
        chk("model_pin_code1", e_code, 1);
        chk("t4_err_latency", err_rise_t - rdy_fall_t, 16);
        chk("t4_err_code", err_code, 1);
        chk("t4_err_index", err_index, 0);

        // abort in WAIT_DONE of entry 1: drains, then done 2 cycles after busy falls
        run_seq(3, -1, -1, 1, 0);
        chk("t5_err_code", err_code, 3);
        chk("t5_err_index", err_index, 1);
        chk("t5_wr_count", wr_count, 1);
        chk("t5_done_after_drain", done_t - slv_fall_t, 2);
        chk("t5_pulses", rise_t.size(), 2);

        // entry 1 transfer never ends: transfer timeout
        run_seq(3, -1, 1, -1, 0);
        chk("t6_err_code", err_code, 2);
        chk("t6_err_index", err_index, 1);
        wait_slave_idle();

        // start+abort together and abort alone in IDLE are ignored
        t = done_cnt;
        @(negedge clk);
        num_entries = 3; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        abort = 1'b0;
        repeat (4) @(negedge clk);
        chk("t7_busy_ignored", busy, 0);
        chk("t7_no_done", done_cnt - t, 0);
        chk("t7_sticky_code", err_code, 2);

        // reset during ISSUE, then a clean rerun from index 0
        build_model(3, -1, -1, -1);
        slv_ord = 0;
        @(negedge clk);
        num_entries = 3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (!spiReady && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) bound_fail("t8_issue", t);
        sup_width = 1;
        reset = 1'b1;
        @(negedge clk);
        chk("t8_reset_outputs", {tbl_rd, tbl_addr, address, data, DUT_EN, spiReady, busy,
                                 done, error, err_code, err_index, wr_count}, 0);
        reset = 1'b0;
        exp_fetch.delete(); exp_wr.delete();
        @(negedge clk);
        sup_width = 0;
        run_seq(3, -1, -1, -1, 0);
        chk("t8_rerun_wr_count", wr_count, 3);

        // randomized tables and slave timing
        slv_rand = 1;
        for (int r = 0; r < 25; r++) begin
            n = int'($urandom_range(0, 8));
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) rom[i] = {1'b1, 8'($urandom), 16'($urandom_range(0, 20))};
                else rom[i] = {1'b0, 24'($urandom)};
            end
            sk = -1;
            if (n > 0 && $urandom_range(0, 9) == 0) begin
                sk = int'($urandom_range(0, n - 1));
                if (rom[sk][24]) sk = -1;
            end
            run_seq(n, sk, -1, -1, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        miscompares++;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog expired");
    end

endmodule
